grid_shift_tx: RTL and testbench



---
 rtl/dino_pkg.sv | 18 +
 rtl/grid_shift_tx_bit_timer.sv | 37 +++
 rtl/grid_shift_tx.sv | 135 +++++++++++++
 tb/tb_grid_shift_tx.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/dino_pkg.sv
// dino_pkg: shared definitions for the LED-grid output path.
//   GRID_W               - width of the grid frame (2 x 8 LEDs)
//   CLK_DIV_DEFAULT      - default sr_clk half-period in clk cycles
//   BLINK_CYCLES_DEFAULT - default game-over blink half-period in clk cycles
//   tx_state_t           - serial transmitter FSM states
package dino_pkg;

  localparam int unsigned GRID_W               = 16;
  localparam int unsigned CLK_DIV_DEFAULT      = 4;
  localparam int unsigned BLINK_CYCLES_DEFAULT = 8_000_000;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH
  } tx_state_t;

endpackage

// File: rtl/grid_shift_tx_bit_timer.sv
// sr_bit_timer: half-period timer for the 595 serial interface.
//   clk       in  system clock
//   reset     in  asynchronous active-low reset
//   start     in  reload the timer (frame accepted)
//   en        in  timer running (SHIFT or LATCH)
//   half_tick out strobe, high for one clk cycle every CLK_DIV cycles while en
module sr_bit_timer
  import dino_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic en,
  output logic half_tick
);

  localparam int unsigned   CW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] count;

  // Reload to CLK_DIV-1 on start, so the first strobe lands CLK_DIV edges later.
  assign half_tick = en && (count == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (start) begin
      count <= RELOAD;
    end else if (en) begin
      count <= half_tick ? RELOAD : count - 1'b1;
    end
  end

endmodule

// File: rtl/grid_shift_tx.sv
// grid_shift_tx: serial transmitter for the 2x8 LED grid through two
// chained 74HC595 shift registers.
//   clk         in  system clock, rising edge
//   reset       in  asynchronous active-low reset
//   grid_in     in  frame to send; bit 15 = top-left LED, bit 0 = bottom-right
//   game_over   in  level; enables blinking of sr_oe_n
//   frame_valid in  producer requests transfer of grid_in
//   frame_ready out block idle and able to accept a frame
//   sr_data     out serial data to 595 SER (MSB first)
//   sr_clk      out shift clock to 595 SRCLK
//   sr_latch    out storage clock to 595 RCLK
//   sr_oe_n     out output enable to 595 OE, active low
// All outputs are registered.
module grid_shift_tx
  import dino_pkg::*;
#(
  parameter int unsigned CLK_DIV      = CLK_DIV_DEFAULT,
  parameter int unsigned BLINK_CYCLES = BLINK_CYCLES_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [GRID_W-1:0] grid_in,
  input  logic              game_over,
  input  logic              frame_valid,
  output logic              frame_ready,
  output logic              sr_data,
  output logic              sr_clk,
  output logic              sr_latch,
  output logic              sr_oe_n
);

  localparam int unsigned   BW         = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

  tx_state_t         state;
  // The MSB goes straight to sr_data on accept, so only the remaining
  // 15 bits need to be held for shifting.
  logic [GRID_W-2:0] shadow;
  logic [3:0]        bit_cnt;
  logic              accept;
  logic              half_tick;

  logic [BW-1:0]     blink_cnt;
  logic              blink_phase;

  assign accept = (state == IDLE) && frame_ready && frame_valid;

  sr_bit_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .start     (accept),
    .en        (state != IDLE),
    .half_tick (half_tick)
  );

  // Transmit FSM. Each half_tick alternates sr_clk; sr_data only moves on the
  // falling half so setup and hold around the rising edge are CLK_DIV cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      shadow      <= '0;
      bit_cnt     <= '0;
      frame_ready <= 1'b0;
      sr_data     <= 1'b0;
      sr_clk      <= 1'b0;
      sr_latch    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          frame_ready <= 1'b1;
          sr_clk      <= 1'b0;
          sr_latch    <= 1'b0;
          if (accept) begin
            shadow      <= grid_in[GRID_W-2:0];
            sr_data     <= grid_in[GRID_W-1];
            bit_cnt     <= 4'd15;
            frame_ready <= 1'b0;
            state       <= SHIFT;
          end
        end

        SHIFT: begin
          if (half_tick) begin
            if (!sr_clk) begin
              sr_clk <= 1'b1;
            end else begin
              sr_clk <= 1'b0;
              if (bit_cnt == '0) begin
                sr_latch <= 1'b1;
                state    <= LATCH;
              end else begin
                bit_cnt <= bit_cnt - 1'b1;
                sr_data <= shadow[GRID_W-2];
                shadow  <= {shadow[GRID_W-3:0], 1'b0};
              end
            end
          end
        end

        LATCH: begin
          if (half_tick) begin
            sr_latch    <= 1'b0;
            frame_ready <= 1'b1;
            state       <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Free-running blink timebase; runs independently of game_over so the
  // blink phase is continuous across game-over episodes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      sr_oe_n     <= 1'b1;
    end else begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
      sr_oe_n <= game_over & blink_phase;
    end
  end

endmodule

// File: tb/tb_grid_shift_tx.sv
// tb_grid_shift_tx: directed self-checking bench for grid_shift_tx.
// dut  : CLK_DIV=2, BLINK_CYCLES=4 (reset, blink, frames, busy, abort)
// dut1 : CLK_DIV=1, BLINK_CYCLES=4 (minimum divider edge case)
module tb_grid_shift_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] grid_in;
  logic        game_over;
  logic        go1;
  logic        fv;
  logic        sel;
  logic        valid0, valid1;

  logic r0, d0, c0, l0, oe0;
  logic r1, d1, c1, l1, oe1;
  logic o_ready, o_data, o_clk, o_latch;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign valid0  = fv & ~sel;
  assign valid1  = fv & sel;
  assign o_ready = sel ? r1 : r0;
  assign o_data  = sel ? d1 : d0;
  assign o_clk   = sel ? c1 : c0;
  assign o_latch = sel ? l1 : l0;

  grid_shift_tx #(.CLK_DIV(2), .BLINK_CYCLES(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .grid_in     (grid_in),
    .game_over   (game_over),
    .frame_valid (valid0),
    .frame_ready (r0),
    .sr_data     (d0),
    .sr_clk      (c0),
    .sr_latch    (l0),
    .sr_oe_n     (oe0)
  );

  grid_shift_tx #(.CLK_DIV(1), .BLINK_CYCLES(4)) dut1 (
    .clk         (clk),
    .reset       (reset),
    .grid_in     (grid_in),
    .game_over   (go1),
    .frame_valid (valid1),
    .frame_ready (r1),
    .sr_data     (d1),
    .sr_clk      (c1),
    .sr_latch    (l1),
    .sr_oe_n     (oe1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends one frame on the selected instance. Cycle c is the interval after
  // accept edge c-1; expectations follow the documented cycle timing.
  // hold keeps frame_valid high throughout; poke_c (>0) pulses frame_valid
  // with grid_in=FFFF in that cycle while busy.
  task automatic run_frame(input logic [15:0] data, input int d, input bit hold, input int poke_c);
    logic [15:0] word;
    int          rises;
    logic        prev_clk;
    logic        exp_clk;
    int          k;
    grid_in  = data;
    fv       = 1'b1;
    word     = '0;
    rises    = 0;
    prev_clk = 1'b0;
    for (int c = 1; c <= 33*d+1; c++) begin
      step();
      if (c == poke_c) begin
        grid_in = 16'hFFFF;
        fv      = 1'b1;
      end else begin
        fv = hold;
      end
      if (c <= 32*d) begin
        k       = (c-1) / (2*d);
        exp_clk = ((c-1) % (2*d)) >= d;
        chk($sformatf("data@%0d", c), 32'(o_data), 32'(data[15-k]));
      end else begin
        exp_clk = 1'b0;
      end
      chk($sformatf("clk@%0d", c),   32'(o_clk),   32'(exp_clk));
      chk($sformatf("latch@%0d", c), 32'(o_latch), 32'((c > 32*d) && (c <= 33*d)));
      chk($sformatf("ready@%0d", c), 32'(o_ready), 32'(c == 33*d+1));
      if (o_clk && !prev_clk) begin
        rises++;
        word = {word[14:0], o_data};
      end
      prev_clk = o_clk;
    end
    chk("rise_count", 32'(rises), 32'd16);
    chk("rx_word",    32'(word),  32'(data));
  endtask

  initial begin
    int rises;
    logic prev_clk;

    sel       = 1'b0;
    fv        = 1'b0;
    grid_in   = '0;
    game_over = 1'b1;
    go1       = 1'b0;
    reset     = 1'b0;

    // Reset values held while reset is low
    repeat (3) step();
    chk("rst_ready", 32'(r0),  32'd0);
    chk("rst_data",  32'(d0),  32'd0);
    chk("rst_clk",   32'(c0),  32'd0);
    chk("rst_latch", 32'(l0),  32'd0);
    chk("rst_oe_n",  32'(oe0), 32'd1);
    chk("rst_oe_n1", 32'(oe1), 32'd1);

    // Release: ready on first edge; blink toggles every 4 cycles
    reset = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      step();
      if (e == 1) begin
        chk("ready_first_edge",  32'(r0), 32'd1);
        chk("ready_first_edge1", 32'(r1), 32'd1);
      end
      chk($sformatf("blink@%0d", e), 32'(oe0), 32'(((e-1) / 4) % 2));
    end
    game_over = 1'b0;
    for (int e = 13; e <= 15; e++) begin
      step();
      chk($sformatf("blink_off@%0d", e), 32'(oe0), 32'd0);
    end

    // Single frame, with a busy-time request carrying FFFF
    run_frame(16'hA53C, 2, 1'b0, 20);
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("no_second_ready@%0d", i), 32'(r0), 32'd1);
      chk($sformatf("no_second_clk@%0d", i),   32'(c0), 32'd0);
    end

    // Back-to-back with frame_valid held: second accept at cycle 67
    run_frame(16'h5A0F, 2, 1'b1, 0);
    run_frame(16'h1234, 2, 1'b0, 0);
    step();

    // Abort after 7th sr_clk rise (edge 26 with CLK_DIV=2)
    grid_in  = 16'hC3A5;
    fv       = 1'b1;
    rises    = 0;
    prev_clk = 1'b0;
    for (int c = 1; c <= 27; c++) begin
      step();
      fv = 1'b0;
      if (c0 && !prev_clk) rises++;
      prev_clk = c0;
    end
    chk("abort_rises", 32'(rises), 32'd7);
    chk("abort_clk_hi", 32'(c0), 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_ready", 32'(r0),  32'd0);
    chk("abort_data",  32'(d0),  32'd0);
    chk("abort_clk",   32'(c0),  32'd0);
    chk("abort_latch", 32'(l0),  32'd0);
    chk("abort_oe_n",  32'(oe0), 32'd1);
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("abort_hold_latch@%0d", i), 32'(l0), 32'd0);
      chk($sformatf("abort_hold_ready@%0d", i), 32'(r0), 32'd0);
    end
    reset = 1'b1;
    step();
    chk("post_abort_ready", 32'(r0), 32'd1);
    run_frame(16'hC3A5, 2, 1'b0, 0);

    // Minimum divider: 34-cycle period, data high only in the 16th bit
    sel = 1'b1;
    step();
    run_frame(16'h0001, 1, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
